// File: rtl/sram_bus_arbiter.sv
// Two-port arbiter and bus sequencer for the latch-addressed SRAM bus.
// Each grant runs one complete read or write cycle; all bus pins come from flops.
module sram_bus_arbiter #(
  parameter int unsigned READ_WAIT   = 1,
  parameter int unsigned WE_CYCLES   = 1,
  parameter bit          ROUND_ROBIN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       p0_valid,
  input  logic       p1_valid,
  output logic       p0_ready,
  output logic       p1_ready,
  input  logic       p0_we,
  input  logic       p1_we,
  input  logic [7:0] p0_addr,
  input  logic [7:0] p1_addr,
  input  logic [7:0] p0_wdata,
  input  logic [7:0] p1_wdata,
  output logic       p0_rsp,
  output logic       p1_rsp,
  output logic [7:0] rsp_rdata,
  output logic [7:0] bus_out,
  output logic       bus_drive,
  input  logic [7:0] bus_in,
  output logic       mem_latch_clk,
  output logic       mem_oe_n,
  output logic       mem_we_n,
  output logic       busy,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    LATCH    = 4'd2,
    RD_WAIT  = 4'd3,
    RD_CAP   = 4'd4,
    TURN     = 4'd5,
    WR_DATA  = 4'd6,
    WR_PULSE = 4'd7,
    WR_HOLD  = 4'd8
  } state_e;

  localparam logic [3:0] RW_LOAD = 4'(READ_WAIT - 1);
  localparam logic [3:0] WE_LOAD = 4'(WE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_grant_q, last_grant_d;
  logic       id_q, id_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;

  logic       drive_q, drive_d;
  logic [7:0] bus_out_q, bus_out_d;
  logic       latch_q, latch_d;
  logic       oe_n_q, oe_n_d;
  logic       we_n_q, we_n_d;
  logic       rsp0_q, rsp0_d;
  logic       rsp1_q, rsp1_d;
  logic [7:0] rdata_q, rdata_d;

  logic pick1, accept;

  // Port 1 wins when alone, or on contention when round-robin says it is its turn.
  always_comb begin
    pick1    = p1_valid && (!p0_valid || (ROUND_ROBIN && !last_grant_q));
    p0_ready = (state_q == IDLE) && en && p0_valid && !pick1;
    p1_ready = (state_q == IDLE) && en && pick1;
    accept   = p0_ready || p1_ready;
  end

  always_comb begin
    id_d         = id_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      id_d         = pick1;
      last_grant_d = pick1;
      we_d         = pick1 ? p1_we    : p0_we;
      addr_d       = pick1 ? p1_addr  : p0_addr;
      wdata_d      = pick1 ? p1_wdata : p0_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ADDR;
      ADDR:    state_d = LATCH;
      LATCH: begin
        if (we_q) begin
          state_d = WR_DATA;
        end else begin
          state_d = RD_WAIT;
          cnt_d   = RW_LOAD;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) state_d = RD_CAP;
        else             cnt_d   = cnt_q - 4'd1;
      end
      RD_CAP:  state_d = TURN;
      TURN:    state_d = IDLE;
      WR_DATA: begin
        state_d = WR_PULSE;
        cnt_d   = WE_LOAD;
      end
      WR_PULSE: begin
        if (cnt_q == '0) state_d = WR_HOLD;
        else             cnt_d   = cnt_q - 4'd1;
      end
      WR_HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus pins are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    drive_d   = 1'b0;
    bus_out_d = '0;
    latch_d   = 1'b0;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    rsp0_d    = 1'b0;
    rsp1_d    = 1'b0;
    rdata_d   = (state_q == RD_CAP) ? bus_in : rdata_q;
    unique case (state_d)
      ADDR: begin
        drive_d   = 1'b1;
        bus_out_d = addr_d;
      end
      LATCH: begin
        drive_d   = 1'b1;
        bus_out_d = addr_d;
        latch_d   = 1'b1;
      end
      RD_WAIT, RD_CAP: begin
        oe_n_d  = 1'b0;
        latch_d = 1'b1;
      end
      TURN: begin
        rsp0_d = !id_d;
        rsp1_d = id_d;
      end
      WR_DATA: begin
        drive_d   = 1'b1;
        bus_out_d = wdata_d;
        latch_d   = 1'b1;
      end
      WR_PULSE: begin
        drive_d   = 1'b1;
        bus_out_d = wdata_d;
        latch_d   = 1'b1;
        we_n_d    = 1'b0;
      end
      WR_HOLD: begin
        drive_d   = 1'b1;
        bus_out_d = wdata_d;
        latch_d   = 1'b1;
        rsp0_d    = !id_d;
        rsp1_d    = id_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drive_q   <= 1'b0;
      bus_out_q <= '0;
      latch_q   <= 1'b0;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      rsp0_q    <= 1'b0;
      rsp1_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      drive_q   <= drive_d;
      bus_out_q <= bus_out_d;
      latch_q   <= latch_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      rsp0_q    <= rsp0_d;
      rsp1_q    <= rsp1_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus_drive     = drive_q;
  assign bus_out       = bus_out_q;
  assign mem_latch_clk = latch_q;
  assign mem_oe_n      = oe_n_q;
  assign mem_we_n      = we_n_q;
  assign p0_rsp        = rsp0_q;
  assign p1_rsp        = rsp1_q;
  assign rsp_rdata     = rdata_q;
  assign busy          = (state_q != IDLE);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: two instances (default timing with round-robin, and
// long read/write timing with fixed priority) checked against a transaction-level model.
module tb_sram_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]      en, p0_valid, p1_valid, p0_ready, p1_ready, p0_we, p1_we;
  logic [1:0][7:0] p0_addr, p1_addr, p0_wdata, p1_wdata, rsp_rdata, bus_out, bus_in;
  logic [1:0]      p0_rsp, p1_rsp, bus_drive, mem_latch_clk, mem_oe_n, mem_we_n, busy;
  logic [1:0][3:0] state_dbg;

  sram_bus_arbiter #(.READ_WAIT(1), .WE_CYCLES(1), .ROUND_ROBIN(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en[0]),
    .p0_valid(p0_valid[0]), .p1_valid(p1_valid[0]), .p0_ready(p0_ready[0]), .p1_ready(p1_ready[0]),
    .p0_we(p0_we[0]), .p1_we(p1_we[0]), .p0_addr(p0_addr[0]), .p1_addr(p1_addr[0]),
    .p0_wdata(p0_wdata[0]), .p1_wdata(p1_wdata[0]), .p0_rsp(p0_rsp[0]), .p1_rsp(p1_rsp[0]),
    .rsp_rdata(rsp_rdata[0]), .bus_out(bus_out[0]), .bus_drive(bus_drive[0]), .bus_in(bus_in[0]),
    .mem_latch_clk(mem_latch_clk[0]), .mem_oe_n(mem_oe_n[0]), .mem_we_n(mem_we_n[0]),
    .busy(busy[0]), .state_dbg(state_dbg[0]));

  sram_bus_arbiter #(.READ_WAIT(3), .WE_CYCLES(2), .ROUND_ROBIN(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en[1]),
    .p0_valid(p0_valid[1]), .p1_valid(p1_valid[1]), .p0_ready(p0_ready[1]), .p1_ready(p1_ready[1]),
    .p0_we(p0_we[1]), .p1_we(p1_we[1]), .p0_addr(p0_addr[1]), .p1_addr(p1_addr[1]),
    .p0_wdata(p0_wdata[1]), .p1_wdata(p1_wdata[1]), .p0_rsp(p0_rsp[1]), .p1_rsp(p1_rsp[1]),
    .rsp_rdata(rsp_rdata[1]), .bus_out(bus_out[1]), .bus_drive(bus_drive[1]), .bus_in(bus_in[1]),
    .mem_latch_clk(mem_latch_clk[1]), .mem_oe_n(mem_oe_n[1]), .mem_we_n(mem_we_n[1]),
    .busy(busy[1]), .state_dbg(state_dbg[1]));

  // External SRAM behind each instance; updated from the pins at every falling edge.
  logic [7:0] sram    [2][256];
  logic [7:0] ref_mem [2][256];
  logic [7:0] lat     [2];
  logic       prev_latch [2];
  assign bus_in[0] = !mem_oe_n[0] ? sram[0][lat[0]] : 8'h00;
  assign bus_in[1] = !mem_oe_n[1] ? sram[1][lat[1]] : 8'h00;

  // Transaction-level reference model
  bit         active[2], m_port[2], m_we[2], last_g[2];
  bit         er0[2], er1[2], acc0[2], acc1[2];
  int         t_acc[2], rsp_cyc[2], we_cnt[2], oe_cnt[2];
  logic [7:0] m_addr[2], m_data[2], m_rd[2], exp_rdata[2];
  int         gport[2][16], gcyc[2][16], gn[2], hs_cyc[2], rsp_seen[2];
  int         cyc;
  int         vectors, miscompares;

  function automatic int rd_wait(input int k);  return (k == 0) ? 1 : 3; endfunction
  function automatic int we_cyc(input int k);   return (k == 0) ? 1 : 2; endfunction
  function automatic bit rr(input int k);       return (k == 0); endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      active[k] = 0; last_g[k] = 1; exp_rdata[k] = 8'h00;
      we_cnt[k] = 0; oe_cnt[k] = 0; prev_latch[k] = 0;
      acc0[k] = 0; acc1[k] = 0; er0[k] = 0; er1[k] = 0;
    end
  endtask

  task automatic check(input int k);
    bit w1;
    if (active[k] && cyc > rsp_cyc[k]) active[k] = 0;
    if (mem_latch_clk[k] && !prev_latch[k]) begin
      lat[k] = bus_out[k];
      chk("latch_addr", k, bus_out[k], m_addr[k]);
      chk("latch_drive", k, bus_drive[k], 1);
    end
    prev_latch[k] = mem_latch_clk[k];
    if (!mem_we_n[k]) begin
      sram[k][lat[k]] = bus_out[k];
      we_cnt[k]++;
      chk("we_data", k, bus_out[k], m_data[k]);
      chk("we_drive", k, bus_drive[k], 1);
    end else if (we_cnt[k] != 0) begin
      chk("we_width", k, we_cnt[k], we_cyc(k));
      we_cnt[k] = 0;
    end
    if (!mem_oe_n[k]) oe_cnt[k]++;
    else if (oe_cnt[k] != 0) begin
      chk("oe_width", k, oe_cnt[k], rd_wait(k) + 1);
      oe_cnt[k] = 0;
    end
    if (active[k] && cyc == rsp_cyc[k]) begin
      if (m_we[k]) begin
        ref_mem[k][m_addr[k]] = m_data[k];
        chk("mem_write", k, sram[k][m_addr[k]], m_data[k]);
      end else begin
        exp_rdata[k] = m_rd[k];
      end
    end
    er0[k] = 0; er1[k] = 0;
    if (!active[k] && en[k]) begin
      w1 = p1_valid[k] && (!p0_valid[k] || (rr(k) && !last_g[k]));
      er1[k] = w1;
      er0[k] = p0_valid[k] && !w1;
    end
    chk("p0_ready", k, p0_ready[k], er0[k]);
    chk("p1_ready", k, p1_ready[k], er1[k]);
    chk("p0_rsp", k, p0_rsp[k], active[k] && cyc == rsp_cyc[k] && !m_port[k]);
    chk("p1_rsp", k, p1_rsp[k], active[k] && cyc == rsp_cyc[k] && m_port[k]);
    chk("rsp_rdata", k, rsp_rdata[k], exp_rdata[k]);
    chk("busy", k, busy[k], active[k] && cyc > t_acc[k]);
    chk("contention", k, bus_drive[k] && !mem_oe_n[k], 0);
    if ((p0_ready[k] && p0_valid[k]) || (p1_ready[k] && p1_valid[k])) begin
      hs_cyc[k] = cyc;
      if (gn[k] < 16) begin
        gport[k][gn[k]] = (p1_ready[k] && p1_valid[k]) ? 1 : 0;
        gcyc[k][gn[k]]  = cyc;
        gn[k]++;
      end
    end
    if (p0_rsp[k] || p1_rsp[k]) rsp_seen[k] = cyc;
  endtask

  task automatic update(input int k);
    bit port;
    acc0[k] = er0[k] && p0_valid[k];
    acc1[k] = er1[k] && p1_valid[k];
    if (acc0[k] || acc1[k]) begin
      port      = acc1[k];
      active[k] = 1;
      t_acc[k]  = cyc;
      m_port[k] = port;
      last_g[k] = port;
      m_we[k]   = port ? p1_we[k]    : p0_we[k];
      m_addr[k] = port ? p1_addr[k]  : p0_addr[k];
      m_data[k] = port ? p1_wdata[k] : p0_wdata[k];
      m_rd[k]   = ref_mem[k][m_addr[k]];
      rsp_cyc[k] = cyc + 4 + (m_we[k] ? we_cyc(k) : rd_wait(k));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) check(k);
    @(posedge clk);
    for (int k = 0; k < 2; k++) update(k);
    cyc++;
    #1;
  endtask

  task automatic set_req(input int k, input bit port, input bit we, input logic [7:0] a, input logic [7:0] d);
    if (!port) begin p0_valid[k] = 1; p0_we[k] = we; p0_addr[k] = a; p0_wdata[k] = d; end
    else       begin p1_valid[k] = 1; p1_we[k] = we; p1_addr[k] = a; p1_wdata[k] = d; end
  endtask

  // Issue the same request on both instances and run until both have completed.
  task automatic issue(input bit port, input bit we, input logic [7:0] a, input logic [7:0] d);
    bit got[2];
    for (int k = 0; k < 2; k++) begin set_req(k, port, we, a, d); got[k] = 0; end
    for (int n = 0; n < 60; n++) begin
      tick();
      for (int k = 0; k < 2; k++)
        if (acc0[k] || acc1[k]) begin got[k] = 1; p0_valid[k] = 0; p1_valid[k] = 0; end
      if (got[0] && got[1] && !active[0] && !active[1]) break;
    end
    for (int k = 0; k < 2; k++) chk("issue_done", k, got[k] && !active[k], 1);
  endtask

  task automatic rand_drive(input int k);
    if (acc0[k]) p0_valid[k] = 0;
    if (acc1[k]) p1_valid[k] = 0;
    if (!p0_valid[k] && $urandom_range(0, 2) == 0)
      set_req(k, 0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom), 8'($urandom));
    if (!p1_valid[k] && $urandom_range(0, 2) == 0)
      set_req(k, 1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom), 8'($urandom));
    en[k] = ($urandom_range(0, 15) != 0);
  endtask

  initial begin
    int t;
    vectors = 0; miscompares = 0; cyc = 0;
    rst_n = 0; en = '0; p0_valid = '0; p1_valid = '0; p0_we = '0; p1_we = '0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    for (int k = 0; k < 2; k++) begin
      lat[k] = 8'h00; gn[k] = 0; t_acc[k] = 0; rsp_cyc[k] = 0; m_addr[k] = 0; m_data[k] = 0;
      for (int a = 0; a < 256; a++) begin
        sram[k][a] = 8'($urandom);
        ref_mem[k][a] = sram[k][a];
      end
      sram[k][8'h10] = 8'h5A; ref_mem[k][8'h10] = 8'h5A;
      sram[k][8'h20] = 8'hC3; ref_mem[k][8'h20] = 8'hC3;
    end
    model_reset();

    #12;
    for (int k = 0; k < 2; k++) begin
      chk("rst_drive", k, bus_drive[k], 0);    chk("rst_bus_out", k, bus_out[k], 0);
      chk("rst_latch", k, mem_latch_clk[k], 0); chk("rst_oe_n", k, mem_oe_n[k], 1);
      chk("rst_we_n", k, mem_we_n[k], 1);       chk("rst_rsp", k, {p0_rsp[k], p1_rsp[k]}, 0);
      chk("rst_rdata", k, rsp_rdata[k], 0);     chk("rst_state", k, state_dbg[k], 0);
    end
    @(posedge clk); #3 rst_n = 1;
    @(posedge clk); #1;
    en = 2'b11;

    // Read of 0x10 on port 0, then write 0xFF/0x3C on port 1
    issue(0, 0, 8'h10, 8'h00);
    for (int k = 0; k < 2; k++) begin
      chk("rd_data", k, rsp_rdata[k], 8'h5A);
      chk("rd_latency", k, rsp_seen[k] - hs_cyc[k], (k == 0) ? 5 : 7);
    end
    issue(1, 1, 8'hFF, 8'h3C);
    for (int k = 0; k < 2; k++) begin
      chk("wr_mem_ff", k, sram[k][8'hFF], 8'h3C);
      chk("wr_rdata_kept", k, rsp_rdata[k], 8'h5A);
      chk("wr_latency", k, rsp_seen[k] - hs_cyc[k], (k == 0) ? 5 : 6);
    end

    // Both ports requesting continuously
    for (int k = 0; k < 2; k++) begin
      gn[k] = 0; set_req(k, 0, 0, 8'h10, 8'h00); set_req(k, 1, 0, 8'h20, 8'h00);
    end
    repeat (26) tick();
    p0_valid = '0; p1_valid = '0;
    repeat (12) tick();
    chk("rr_grants", 0, gn[0], 5);
    for (int i = 0; i < 4; i++) begin
      chk("rr_port", 0, gport[0][i], i % 2);
      chk("rr_spacing", 0, gcyc[0][i + 1] - gcyc[0][i], 6);
    end
    chk("fixed_grants", 1, gn[1], 4);
    for (int i = 0; i < 4; i++) chk("fixed_port", 1, gport[1][i], 0);

    // Reset asserted in the middle of the write pulse
    for (int k = 0; k < 2; k++) set_req(k, 0, 1, 8'h33, 8'hA5);
    tick();
    chk("wr_accept", 0, acc0[0] && acc0[1], 1);
    t = cyc - 1;
    p0_valid = '0;
    for (int n = 0; n < 10 && cyc < t + 4; n++) tick();
    #2;
    for (int k = 0; k < 2; k++) chk("pulse_we_low", k, mem_we_n[k], 0);
    rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("mid_rst_we_n", k, mem_we_n[k], 1);
      chk("mid_rst_drive", k, bus_drive[k], 0);
      chk("mid_rst_state", k, state_dbg[k], 0);
      chk("mid_rst_rsp", k, {p0_rsp[k], p1_rsp[k]}, 0);
    end
    model_reset();
    repeat (2) tick();
    rst_n = 1;
    tick();
    for (int k = 0; k < 2; k++) chk("no_partial_write", k, sram[k][8'h33], ref_mem[k][8'h33]);
    issue(0, 0, 8'h10, 8'h00);
    for (int k = 0; k < 2; k++) chk("post_rst_read", k, rsp_rdata[k], 8'h5A);

    // Randomised traffic with occasional enable drops
    for (int n = 0; n < 400; n++) begin
      tick();
      for (int k = 0; k < 2; k++) rand_drive(k);
    end
    for (int n = 0; n < 40; n++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        en[k] = 1;
        if (acc0[k]) p0_valid[k] = 0;
        if (acc1[k]) p1_valid[k] = 0;
      end
    end
    for (int k = 0; k < 2; k++) chk("drained", k, {p0_valid[k], p1_valid[k], busy[k]}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
